// File: rtl/gpmc_sync_slave_if.sv
// GPMC chip-select-1 pad bundle: multiplexed AD bus plus control strobes.
// The master side is the host (or its model); the slave side is this FPGA responder.
interface gpmc_sync_slave_if;
    logic [15:0] gpmc_ad_in;
    logic [15:0] gpmc_ad_out;
    logic        gpmc_ad_oe;
    logic        gpmc_advn;
    logic        gpmc_csn1;
    logic        gpmc_wein;
    logic        gpmc_oen;

    modport master (
        output gpmc_ad_in,
        output gpmc_advn,
        output gpmc_csn1,
        output gpmc_wein,
        output gpmc_oen,
        input  gpmc_ad_out,
        input  gpmc_ad_oe
    );

    modport slave (
        input  gpmc_ad_in,
        input  gpmc_advn,
        input  gpmc_csn1,
        input  gpmc_wein,
        input  gpmc_oen,
        output gpmc_ad_out,
        output gpmc_ad_oe
    );
endinterface

// File: rtl/gpmc_sync_slave.sv
// Synchronous address/data-multiplexed GPMC responder that turns host bursts
// into single-cycle register-file write and read strobes.
module gpmc_sync_slave #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  gpmc_clk,
    input  logic                  reset_n,
    gpmc_sync_slave_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_wr_en,
    output logic [15:0]           reg_wr_data,
    output logic                  reg_rd_en,
    input  logic [15:0]           reg_rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_e                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   base_q,     base_d;
    logic [ADDR_WIDTH-1:0]   beat_q,     beat_d;
    logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
    logic                    wr_en_q,    wr_en_d;
    logic [15:0]             wr_data_q,  wr_data_d;
    logic                    rd_en_q,    rd_en_d;
    logic [15:0]             ad_out_q,   ad_out_d;
    logic                    ad_oe_q,    ad_oe_d;
    logic [ADDR_WIDTH-1:0]   beat_addr_s;

    assign beat_addr_s = base_q + beat_q;

    // Next-state and output decode; address phases win over any state.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        beat_d     = beat_q;
        reg_addr_d = reg_addr_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        rd_en_d    = rd_en_q;
        ad_out_d   = ad_out_q;
        ad_oe_d    = 1'b0;

        if (bus.gpmc_csn1) begin
            state_d = IDLE;
            rd_en_d = 1'b0;
        end else if (!bus.gpmc_advn) begin
            base_d = bus.gpmc_ad_in[ADDR_WIDTH-1:0];
            beat_d = '0;
            if (!bus.gpmc_wein) begin
                state_d = WRITE;
                rd_en_d = 1'b0;
            end else begin
                state_d    = READ;
                reg_addr_d = bus.gpmc_ad_in[ADDR_WIDTH-1:0];
                rd_en_d    = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    rd_en_d = 1'b0;
                end
                WRITE: begin
                    rd_en_d = 1'b0;
                    if (!bus.gpmc_wein) begin
                        wr_en_d    = 1'b1;
                        reg_addr_d = beat_addr_s;
                        wr_data_d  = bus.gpmc_ad_in;
                        beat_d     = beat_q + ADDR_ONE;
                    end else begin
                        wr_en_d = 1'b0;
                    end
                end
                READ: begin
                    ad_out_d = reg_rd_data;
                    // A write enable during a read is honoured as a write beat.
                    if (!bus.gpmc_wein) begin
                        state_d    = WRITE;
                        rd_en_d    = 1'b0;
                        wr_en_d    = 1'b1;
                        reg_addr_d = beat_addr_s;
                        wr_data_d  = bus.gpmc_ad_in;
                        beat_d     = beat_q + ADDR_ONE;
                    end else if (!bus.gpmc_oen) begin
                        ad_oe_d    = 1'b1;
                        rd_en_d    = 1'b1;
                        reg_addr_d = reg_addr_q + ADDR_ONE;
                    end else begin
                        rd_en_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rd_en_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge gpmc_clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            beat_q     <= '0;
            reg_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 16'h0000;
            rd_en_q    <= 1'b0;
            ad_out_q   <= 16'h0000;
            ad_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            beat_q     <= beat_d;
            reg_addr_q <= reg_addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
        end
    end

    assign reg_addr        = reg_addr_q;
    assign reg_wr_en       = wr_en_q;
    assign reg_wr_data     = wr_data_q;
    assign reg_rd_en       = rd_en_q;
    assign bus.gpmc_ad_out = ad_out_q;
    assign bus.gpmc_ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_gpmc_sync_slave.sv
// Directed bench for gpmc_sync_slave: host bus model on negedge, registered
// read-data model, hand-computed expectations checked just after each posedge.
module tb_gpmc_sync_slave;

    logic        clk;
    logic        reset_n;
    logic [15:0] reg_addr;
    logic        reg_wr_en;
    logic [15:0] reg_wr_data;
    logic        reg_rd_en;
    logic [15:0] reg_rd_data;

    int errors;
    int checks;
    int wr_cnt;
    int rd_cnt;
    int oe_cnt;
    int wr_base;
    int rd_base;
    int oe_base;

    logic [15:0] rd_exp [4];

    gpmc_sync_slave_if bus ();

    gpmc_sync_slave #(.ADDR_WIDTH(16)) dut (
        .gpmc_clk    (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file read model: one-cycle registered latency, data = addr ^ 0x5A5A.
    always @(posedge clk) begin
        if (reg_rd_en) reg_rd_data <= reg_addr ^ 16'h5A5A;
    end

    // Strobe and output-enable activity counters.
    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) wr_cnt <= wr_cnt + 1;
        if (reg_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
        if (bus.gpmc_ad_oe === 1'b1) oe_cnt <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One host bus cycle: drive on negedge, return just after the sampling posedge.
    task automatic step(input logic csn, input logic advn, input logic wein,
                        input logic oen, input logic [15:0] ad);
        @(negedge clk);
        bus.gpmc_csn1  = csn;
        bus.gpmc_advn  = advn;
        bus.gpmc_wein  = wein;
        bus.gpmc_oen   = oen;
        bus.gpmc_ad_in = ad;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0;
        wr_cnt = 0; rd_cnt = 0; oe_cnt = 0;
        reg_rd_data = 16'h0000;
        reset_n = 1'b0;
        bus.gpmc_csn1 = 1'b1; bus.gpmc_advn = 1'b1; bus.gpmc_wein = 1'b1;
        bus.gpmc_oen = 1'b1; bus.gpmc_ad_in = 16'h0000;

        // Reset: four clocks low, then release.
        for (int i = 0; i < 4; i++) idle_step();
        reset_n = 1'b1;
        idle_step();
        check("rst_addr",    32'(reg_addr),        32'h0);
        check("rst_wr_en",   32'(reg_wr_en),       32'h0);
        check("rst_wr_data", 32'(reg_wr_data),     32'h0);
        check("rst_rd_en",   32'(reg_rd_en),       32'h0);
        check("rst_ad_out",  32'(bus.gpmc_ad_out), 32'h0);
        check("rst_ad_oe",   32'(bus.gpmc_ad_oe),  32'h0);

        // Single write repeated four times.
        wr_base = wr_cnt; rd_base = rd_cnt; oe_base = oe_cnt;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 16'h1000);
            check("sw_a_wr_en", 32'(reg_wr_en), 32'h0);
            step(1'b0, 1'b1, 1'b0, 1'b1, 16'hABCD);
            check("sw_wr_en",   32'(reg_wr_en),   32'h1);
            check("sw_addr",    32'(reg_addr),    32'h1000);
            check("sw_data",    32'(reg_wr_data), 32'hABCD);
            idle_step();
            check("sw_end_wr_en", 32'(reg_wr_en), 32'h0);
        end
        idle_step();
        check("sw_pulses",  32'(wr_cnt - wr_base), 32'd4);
        check("sw_no_rd",   32'(rd_cnt - rd_base), 32'd0);
        check("sw_no_oe",   32'(oe_cnt - oe_base), 32'd0);

        // Burst write with a wait state between the second and third beat.
        wr_base = wr_cnt;
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0020);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1111);
        check("bw0_addr", 32'(reg_addr), 32'h0020);
        check("bw0_data", 32'(reg_wr_data), 32'h1111);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h2222);
        check("bw1_addr", 32'(reg_addr), 32'h0021);
        check("bw1_data", 32'(reg_wr_data), 32'h2222);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'hDEAD);
        check("bw_wait_wr_en", 32'(reg_wr_en), 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h3333);
        check("bw2_wr_en", 32'(reg_wr_en), 32'h1);
        check("bw2_addr", 32'(reg_addr), 32'h0022);
        check("bw2_data", 32'(reg_wr_data), 32'h3333);
        idle_step();
        idle_step();
        check("bw_pulses", 32'(wr_cnt - wr_base), 32'd3);

        // Burst read of four words from 0x0040.
        rd_exp[0] = 16'h5A1A; rd_exp[1] = 16'h5A1B;
        rd_exp[2] = 16'h5A18; rd_exp[3] = 16'h5A19;
        wr_base = wr_cnt;
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0040);
        check("br_a_oe",    32'(bus.gpmc_ad_oe), 32'h0);
        check("br_a_rd_en", 32'(reg_rd_en),      32'h1);
        check("br_a_addr",  32'(reg_addr),       32'h0040);
        for (int n = 1; n <= 6; n++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
            check($sformatf("br_oe_%0d", n), 32'(bus.gpmc_ad_oe), 32'h1);
            if (n >= 2 && n <= 5)
                check($sformatf("br_word_%0d", n - 2), 32'(bus.gpmc_ad_out), 32'(rd_exp[n-2]));
        end
        idle_step();
        check("br_end_oe",    32'(bus.gpmc_ad_oe), 32'h0);
        check("br_end_rd_en", 32'(reg_rd_en),      32'h0);
        check("br_no_wr",     32'(wr_cnt - wr_base), 32'd0);

        // Reset in the middle of a read burst.
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0080);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        check("mr_oe_before", 32'(bus.gpmc_ad_oe), 32'h1);
        reset_n = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        check("mr_oe",    32'(bus.gpmc_ad_oe), 32'h0);
        check("mr_rd_en", 32'(reg_rd_en),      32'h0);
        check("mr_addr",  32'(reg_addr),       32'h0);
        for (int i = 0; i < 3; i++) idle_step();
        reset_n = 1'b1;
        idle_step();

        // Address wrap, then restart with chip select held low.
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
        check("wrap0_addr", 32'(reg_addr), 32'hFFFF);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h5678);
        check("wrap1_wr_en", 32'(reg_wr_en), 32'h1);
        check("wrap1_addr",  32'(reg_addr),  32'h0000);
        check("wrap1_data",  32'(reg_wr_data), 32'h5678);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100);
        check("rs_a_wr_en", 32'(reg_wr_en), 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999);
        check("rs_wr_en", 32'(reg_wr_en),   32'h1);
        check("rs_addr",  32'(reg_addr),    32'h0100);
        check("rs_data",  32'(reg_wr_data), 32'h9999);
        idle_step();

        // Abort between address and data phase, then a stray data-like cycle.
        wr_base = wr_cnt;
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0300);
        idle_step();
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h7777);
        check("ab_stray_wr_en", 32'(reg_wr_en), 32'h0);
        idle_step();
        idle_step();
        check("ab_pulses", 32'(wr_cnt - wr_base), 32'd0);
        check("ab_hold_addr", 32'(reg_addr), 32'h0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpmc_sync_slave.md
Name: gpmc_sync_slave

Overview:
- FPGA-side responder for the ARM GPMC synchronous, address/data-multiplexed 16-bit bus (chip select 1).
- Decodes host write and read transactions into a simple register-file port: address, write strobe with data, and read strobe with read data returned.
- Sits in top between the gpmc_* pads and the internal register/LED-control logic.

Parameters:
- ADDR_WIDTH, 16: width of word address taken from gpmc_ad_in[ADDR_WIDTH-1:0]; 1..16.

Ports:
- gpmc_clk  in  1  GPMC bus clock. Only toggles during host transactions or host reset clocking.
- reset_n  in  1  Synchronous reset, active-low, sampled on gpmc_clk.
- gpmc_ad_in  in  16  Input side of the AD pad.
- gpmc_ad_out  out  16  Read data to the AD pad.
- gpmc_ad_oe  out  1  AD pad output enable, 1 = drive.
- gpmc_advn  in  1  Address valid, active-low.
- gpmc_csn1  in  1  Chip select, active-low.
- gpmc_wein  in  1  Write enable, active-low.
- gpmc_oen  in  1  Output enable, active-low.
- reg_addr  out  ADDR_WIDTH  Register word address for the current beat.
- reg_wr_en  out  1  One-cycle write strobe.
- reg_wr_data  out  16  Write data, valid with reg_wr_en.
- reg_rd_en  out  1  Read strobe.
- reg_rd_data  in  16  Read data. Must be valid in the cycle after reg_rd_en is high at that address (1-cycle registered latency).

Behaviour:
- All logic is on posedge gpmc_clk. Host drives on negedge; the block samples on posedge.
- Reset (reset_n=0 at an edge): state IDLE; reg_addr=0, reg_wr_en=0, reg_wr_data=0, reg_rd_en=0, gpmc_ad_out=0, gpmc_ad_oe=0. The host must run gpmc_clk while reset_n is low for reset to take effect.
- States: IDLE, WRITE, READ.
- Address phase, edge A (csn1=0, advn=0), accepted from any state:
  - Latch addr = gpmc_ad_in[ADDR_WIDTH-1:0]; beat counter = 0.
  - If wein=0, go to WRITE.
  - Otherwise go to READ, set reg_addr=addr and reg_rd_en=1 after A.
- WRITE:
  - Each edge with csn1=0, advn=1, wein=0 is a data beat.
  - After that edge: reg_wr_en=1 for exactly one cycle, reg_addr = addr+beat, reg_wr_data = gpmc_ad_in. Beat counter then increments.
  - Write latency: 1 cycle from sampling edge to strobe.
  - Edges with wein=1 while csn1=0 produce no strobe and stay in WRITE (wait states).
- READ:
  - reg_rd_en stays 1 and reg_addr increments by 1 each edge while csn1=0 and oen=0. While oen=1 (pre-access), reg_addr holds and reg_rd_en=1.
  - reg_rd_data is registered into gpmc_ad_out every edge.
  - The word for addr+n is on the bus from edge A+2+n until A+3+n; the host samples at A+3+n. Host RDACCESSTIME is configured to 3.
  - gpmc_ad_oe=1 from the first edge after A with csn1=0 and oen=0; it never rises at A itself (bus turnaround).
  - Up to 2 speculative reads past the last consumed word occur at burst end. Register reads must be side-effect free.
- Termination: any edge with csn1=1 goes to IDLE and, after that edge, sets reg_wr_en=0, reg_rd_en=0 and gpmc_ad_oe=0. reg_addr, reg_wr_data and gpmc_ad_out hold.
- oen=1 at any edge drops gpmc_ad_oe after that edge.
- wein=0 and oen=0 together are treated as a write; gpmc_ad_oe is forced 0.
- A new address phase with csn1 still low restarts the transaction: the beat counter clears, and any pending strobe from the prior beat still issues.
- Address arithmetic is modulo 2^ADDR_WIDTH (0xFFFF+1 → 0x0000).
- IDLE with csn1=0 and advn=1 (no address phase seen): ignore, no strobes.

Test Plan:
- Reset: clock 4 cycles with reset_n=0, then release → all outputs 0, gpmc_ad_oe=0. Repeat mid-READ burst → gpmc_ad_oe drops after the first reset edge.
- Single write, repeated 4×: addr 0x1000 then data 0xABCD, csn1 high on the next negedge → exactly four reg_wr_en pulses, each reg_addr=0x1000, reg_wr_data=0xABCD. No reg_rd_en; gpmc_ad_oe=0 throughout.
- Burst write: addr 0x0020, data 0x1111/0x2222/0x3333 → strobes at 0x0020/0x0021/0x0022 with matching data, one cycle after each sampling edge.
- Burst read of 4 words: addr 0x0040, model returns data = addr ^ 0x5A5A → host samples 0x5A1A, 0x5A1B, 0x5A18, 0x5A19 at A+3..A+6. gpmc_ad_oe is 0 at A and 1 from A+1 until the edge csn1 rises.
- Wrap and restart:
  - Write burst at 0xFFFF, 2 beats → addresses 0xFFFF then 0x0000.
  - Address phase 0x0100 mid-burst with csn1 low → next beat writes 0x0100.
- Abort: csn1 rises between address and data phase → no reg_wr_en. A later stray data-like cycle in IDLE produces no strobe.
